// File: rtl/ccg_sweep_sequencer.sv
// Sweep sequencer for a 4-input / 6-output CCG netlist instance.
// Steps a wrap-around range of input vectors, waits a settle time per
// vector, captures the six outputs, streams each result over valid/ready
// and folds every accepted result into a 16-bit rotating signature.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; dut_x and sig hold the last sweep
// ST_SETTLE| vector applied on dut_x, counting down the settle time
// ST_OUT   | result presented, waiting for res_ready
// ST_DONE  | one-cycle done pulse after the last accepted result
module ccg_sweep_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  first_vec,
    input  logic [3:0]  last_vec,
    output logic [3:0]  dut_x,
    input  logic [5:0]  dut_f,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_vec,
    output logic [5:0]  res_f,
    output logic [15:0] sig,
    output logic        busy,
    output logic        done
);

    // Legal settle range is 1..15, so the reload value always fits 4 bits.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [3:0]  cur_q,     cur_d;
    logic [3:0]  last_q,    last_d;
    logic [3:0]  res_vec_q, res_vec_d;
    logic [5:0]  res_f_q,   res_f_d;
    logic [15:0] sig_q,     sig_d;

    // State and datapath registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_q     <= '0;
            last_q    <= '0;
            res_vec_q <= '0;
            res_f_q   <= '0;
            sig_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            res_vec_q <= res_vec_d;
            res_f_q   <= res_f_d;
            sig_q     <= sig_d;
        end
    end

    // Next-state logic: settle down-counter, capture, accept and signature fold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        last_d    = last_q;
        res_vec_d = res_vec_q;
        res_f_d   = res_f_q;
        sig_d     = sig_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = first_vec;
                    last_d  = last_vec;
                    sig_d   = '0;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                // A count of 1 means this edge is the one that reaches zero.
                if (cnt_q == 4'd1) begin
                    res_f_d   = dut_f;
                    res_vec_d = cur_q;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    sig_d = {sig_q[14:0], sig_q[15]} ^ {10'b0, res_f_q};
                    if (cur_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + 4'd1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode registered state only, so no input reaches an output combinationally.
    assign dut_x     = cur_q;
    assign res_valid = (state_q == ST_OUT);
    assign res_vec   = res_vec_q;
    assign res_f     = res_f_q;
    assign sig       = sig_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_OUT);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ccg_sweep_sequencer.sv
// Bench for ccg_sweep_sequencer: two instances (settle 1 and 3) share the
// stimulus; an event-level model predicts every output each cycle.
module tb_ccg_sweep_sequencer;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       res_ready = 1'b1;
    logic [3:0] first_vec = 4'd0;
    logic [3:0] last_vec = 4'd0;
    logic       f_mode = 1'b0;
    logic       chk_en = 1'b0;

    logic [1:0][3:0]  dut_x_w;
    logic [1:0][5:0]  dut_f_w;
    logic [1:0]       res_valid_w;
    logic [1:0][3:0]  res_vec_w;
    logic [1:0][5:0]  res_f_w;
    logic [1:0][15:0] sig_w;
    logic [1:0]       busy_w;
    logic [1:0]       done_w;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt [2];

    // Model state: vectors left in the sweep, edges since the vector was applied.
    logic        m_act   [2];
    logic        m_done  [2];
    logic        m_valid [2];
    logic [3:0]  m_x     [2];
    logic [3:0]  m_rvec  [2];
    logic [5:0]  m_rf    [2];
    logic [15:0] m_sig   [2];
    int          m_left  [2];
    int          m_age   [2];
    int          m_acc   [2];

    // Netlist stand-in: plain pass-through, or a mix that exercises the upper bits.
    function automatic logic [5:0] fmodel(input logic [3:0] x, input logic m);
        return m ? {x[0] ^ x[3], x[1] & x[2], x ^ 4'h9} : {2'b00, x};
    endfunction

    assign dut_f_w[0] = fmodel(dut_x_w[0], f_mode);
    assign dut_f_w[1] = fmodel(dut_x_w[1], f_mode);

    ccg_sweep_sequencer #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .first_vec(first_vec), .last_vec(last_vec),
        .dut_x(dut_x_w[0]), .dut_f(dut_f_w[0]),
        .res_valid(res_valid_w[0]), .res_ready(res_ready),
        .res_vec(res_vec_w[0]), .res_f(res_f_w[0]), .sig(sig_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    ccg_sweep_sequencer #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .first_vec(first_vec), .last_vec(last_vec),
        .dut_x(dut_x_w[1]), .dut_f(dut_f_w[1]),
        .res_valid(res_valid_w[1]), .res_ready(res_ready),
        .res_vec(res_vec_w[1]), .res_f(res_f_w[1]), .sig(sig_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Final signature of a whole range, straight from the folding rule.
    function automatic logic [15:0] sig_of_range(input logic [3:0] f, input logic [3:0] l,
                                                 input logic m);
        logic [15:0] s;
        logic [3:0]  v;
        logic [3:0]  n;
        s = 16'h0;
        v = f;
        n = l - f;
        for (int j = 0; j <= int'(n); j++) begin
            s = {s[14:0], s[15]} ^ {10'b0, fmodel(v, m)};
            v = v + 4'd1;
        end
        return s;
    endfunction

    function automatic logic [32:0] pack_act(input int i);
        return {dut_x_w[i], res_valid_w[i], res_vec_w[i], res_f_w[i], sig_w[i],
                busy_w[i], done_w[i]};
    endfunction

    function automatic logic [32:0] pack_exp(input int i);
        return {m_x[i], m_valid[i], m_rvec[i], m_rf[i], m_sig[i], m_act[i], m_done[i]};
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int s;
            s = (i == 0) ? S0 : S1;
            if (!rst_n) begin
                m_act[i] = 1'b0;  m_done[i] = 1'b0; m_valid[i] = 1'b0;
                m_x[i]   = 4'd0;  m_rvec[i] = 4'd0; m_rf[i]    = 6'd0;
                m_sig[i] = 16'd0; m_left[i] = 0;    m_age[i]   = 0;
            end else if (m_act[i]) begin
                if (m_valid[i]) begin
                    if (res_ready) begin
                        m_sig[i]   = {m_sig[i][14:0], m_sig[i][15]} ^ {10'b0, m_rf[i]};
                        m_valid[i] = 1'b0;
                        m_acc[i]++;
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_act[i]  = 1'b0;
                            m_done[i] = 1'b1;
                        end else begin
                            m_x[i]   = m_x[i] + 4'd1;
                            m_age[i] = 0;
                        end
                    end
                end else begin
                    m_age[i]++;
                    if (m_age[i] == s) begin
                        m_valid[i] = 1'b1;
                        m_rvec[i]  = m_x[i];
                        m_rf[i]    = fmodel(m_x[i], f_mode);
                    end
                end
            end else if (m_done[i]) begin
                m_done[i] = 1'b0;
            end else if (start) begin
                logic [3:0] d;
                d         = last_vec - first_vec;
                m_act[i]  = 1'b1;
                m_x[i]    = first_vec;
                m_left[i] = int'(d) + 1;
                m_age[i]  = 0;
                m_sig[i]  = 16'd0;
            end
        end
    endtask

    initial begin
        m_acc[0] = 0;
        m_acc[1] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    check_eq($sformatf("cycle_i%0d", i), {31'b0, pack_act(i)}, {31'b0, pack_exp(i)});
                    if (done_w[i]) done_cnt[i]++;
                end
            end
        end
    end

    // mode: 0 ready=1, 1 random ready, 2 ready held low early on,
    //       3 start pulsed mid-sweep, 4 start pulsed while in DONE
    task automatic sweep(input logic [3:0] f, input logic [3:0] l, input int mode,
                         output int k0, output int k1);
        int k;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        k0 = -1;
        k1 = -1;
        @(negedge clk);
        first_vec = f;
        last_vec  = l;
        start     = 1'b1;
        res_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 2000) begin
            if (done_w[0] && k0 < 0) k0 = k;
            if (done_w[1] && k1 < 0) k1 = k;
            if (k0 >= 0 && k1 >= 0) break;
            case (mode)
                1:       res_ready = 1'($urandom_range(0, 1));
                2:       res_ready = !(k >= 4 && k < 10);
                default: res_ready = 1'b1;
            endcase
            start = (mode == 3 && k == 6) || (mode == 4 && k == k0);
            if (start) begin
                first_vec = 4'($urandom);
                last_vec  = 4'($urandom);
            end
            if (mode == 2 && k == 9) begin
                check_eq("bp_valid_held", {63'b0, res_valid_w[1]}, 64'd1);
                check_eq("bp_vec_held", {60'b0, res_vec_w[1]}, {60'b0, f});
            end
            @(negedge clk);
            k++;
        end
        if (k0 < 0 || k1 < 0) check_eq("sweep_timeout", 64'd0, 64'd1);
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("done_pulses_i%0d", i), done_cnt[i], 64'd1);
            check_eq($sformatf("sig_final_i%0d", i), {48'b0, sig_w[i]},
                     {48'b0, sig_of_range(f, l, f_mode)});
            check_eq($sformatf("x_hold_i%0d", i), {60'b0, dut_x_w[i]}, {60'b0, l});
        end
    endtask

    initial begin
        int k0, k1, n, base;
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_async_i0", {31'b0, pack_act(0)}, 64'd0);
        check_eq("rst_async_i1", {31'b0, pack_act(1)}, 64'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_no_done_i0", done_cnt[0], 64'd0);
        check_eq("idle_no_done_i1", done_cnt[1], 64'd0);

        sweep(4'd5, 4'd5, 0, k0, k1);
        check_eq("single_sig", {48'b0, sig_w[0]}, 64'h0005);
        check_eq("single_done_at_i0", k0, 64'd3);
        check_eq("single_done_at_i1", k1, 64'd5);

        sweep(4'd5, 4'd6, 0, k0, k1);
        check_eq("two_sig", {48'b0, sig_w[0]}, 64'h000C);
        check_eq("two_done_at_i0", k0, 64'd5);
        check_eq("two_done_at_i1", k1, 64'd9);

        sweep(4'd0, 4'd15, 0, k0, k1);
        check_eq("full_done_at_i0", k0, 64'd33);
        check_eq("full_done_at_i1", k1, 64'd65);

        sweep(4'd14, 4'd1, 0, k0, k1);
        check_eq("wrap_done_at_i0", k0, 64'd9);
        check_eq("wrap_done_at_i1", k1, 64'd17);

        f_mode = 1'b1;
        sweep(4'd2, 4'd1, 0, k0, k1);
        sweep(4'd9, 4'd11, 2, k0, k1);
        sweep(4'd0, 4'd15, 3, k0, k1);
        sweep(4'd7, 4'd8, 4, k0, k1);

        for (int r = 0; r < 12; r++) begin
            f_mode = 1'($urandom);
            sweep(4'($urandom), 4'($urandom), int'($urandom_range(0, 1)), k0, k1);
        end

        // Abort a sweep by reset after its seventh accepted result.
        f_mode = 1'b0;
        base = m_acc[0];
        @(negedge clk);
        first_vec = 4'd0;
        last_vec  = 4'd15;
        start     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        n = 0;
        while (m_acc[0] - base < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("abort_timeout", 64'd0, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_i0", {31'b0, pack_act(0)}, 64'd0);
        check_eq("rst_mid_i1", {31'b0, pack_act(1)}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_done_i0", done_cnt[0], 64'd0);
        check_eq("rst_mid_no_done_i1", done_cnt[1], 64'd0);
        sweep(4'd3, 4'd3, 0, k0, k1);
        check_eq("after_rst_sig_i0", {48'b0, sig_w[0]}, 64'h0003);
        check_eq("after_rst_sig_i1", {48'b0, sig_w[1]}, 64'h0003);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ccg_sweep_sequencer.md
# ccg_sweep_sequencer

Sequencer that drives one 4-input / 6-output combinational netlist from the CCG dataset through a programmable, wrap-around range of input vectors. It waits a fixed settle time per vector, captures the six outputs, and streams each result over a valid/ready interface. It also folds every accepted result into a 16-bit signature. It sits between a test/characterisation host and the netlist instance, and is the only driver of the netlist's x0..x3 inputs.

## Interface
- SETTLE_CYCLES, 1, number of clock edges between applying a vector on dut_x and sampling dut_f; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- first_vec  in  4  first input vector of the sweep; sampled with start.
- last_vec  in  4  last input vector, inclusive; sampled with start.
- dut_x  out  4  drive to netlist inputs; bit0=x0 … bit3=x3.
- dut_f  in  6  netlist outputs; bit0=f1 … bit5=f6.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_vec  out  4  vector that produced res_f.
- res_f  out  6  captured dut_f.
- sig  out  16  running signature.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, SETTLE, OUT, DONE.
- Reset: state IDLE. dut_x, res_vec, res_f and sig are 0. res_valid, busy and done are 0.
- IDLE, start=1:
  - Latch first_vec and last_vec; cur=first_vec; dut_x=first_vec.
  - sig cleared to 0; busy=1; settle counter loaded with SETTLE_CYCLES; go to SETTLE.
- SETTLE: decrement the counter each edge. On the edge where it reaches 0:
  - res_f=dut_f; res_vec=cur; res_valid=1; go to OUT.
- OUT: hold res_valid, res_vec, res_f and dut_x stable while res_ready=0. On an edge with res_valid&res_ready:
  - sig = {sig[14:0],sig[15]} ^ {10'b0,res_f}; res_valid=0.
  - If cur==last_vec: go to DONE; busy=0; done=1.
  - Otherwise: cur=cur+1 mod 16; dut_x=cur+1; reload the counter; go to SETTLE.
- DONE: done is high for exactly one cycle. Next edge: done=0, go to IDLE.
- Range wraps modulo 16. Vector count = ((last_vec−first_vec) mod 16)+1, i.e. 1..16.
  - first=last gives 1 vector.
  - first=N, last=N−1 gives all 16 vectors.
  - first=14, last=1 gives 14,15,0,1.
- start while busy or in DONE is ignored. It is not queued.
- After a sweep, dut_x holds the last vector and sig holds the final signature until the next start or reset.
- Reset asserted mid-sweep aborts immediately. All outputs return to reset values, no done pulse is produced, and the partial signature is lost.

## Timing
- Edge E0 samples start in IDLE → from E0: busy=1, dut_x=first_vec.
- Vector applied at edge k → dut_f sampled and res_valid=1 from edge k+SETTLE_CYCLES.
- Accept at edge h → the next vector appears on dut_x from h, and res_valid=0 from h.
- Throughput with res_ready held at 1: one result per SETTLE_CYCLES+1 cycles.
- The last accept at edge h gives busy=0 and done=1 during the cycle after h, and done=0 after h+1. The earliest a new start can be accepted is edge h+2.
- No combinational path from any input to any output.

## Test plan
Bench model: dut_f = {2'b00, dut_x} unless stated otherwise.
- **Reset values:** Assert rst_n=0 asynchronously between edges → every output is 0 immediately. Release, idle 5 cycles → outputs stay 0, done never pulses.
- **Single vector:** SETTLE_CYCLES=1, res_ready=1, start with first=last=5 at E0.
  - res_valid=1 from E0+1 with res_vec=5, res_f=6'h05; accepted at E0+2.
  - sig=16'h0005; done high for exactly one cycle after E0+2.
- **Two vectors:** first=5, last=6 → results (5,05) then (6,06); final sig=16'h000C.
- **Full sweep and wrap:**
  - first=0, last=15, SETTLE_CYCLES=1, ready=1 → 16 results in order 0..15, one every 2 cycles; last accept at E0+32; done pulses once.
  - Repeat with first=14, last=1 → res_vec sequence 14,15,0,1.
- **Backpressure and ignored start:**
  - SETTLE_CYCLES=3. Hold res_ready=0 for 4 cycles while res_valid=1 → res_vec, res_f and dut_x do not change.
  - Pulse start while busy → no effect on the range or on sig.
- **Reset mid-sweep:** Sweep 0..15 and assert rst_n=0 after the 7th accept → all outputs 0, no done. Release, start with first=last=3 → sig=16'h0003.
